// File: rtl/rdo_fifo_arbiter.sv
// rdo_fifo_arbiter
//   Shares one 16-bit readout FIFO between N_SRC VA/ADC front-end controllers.
//   Whole event frames are granted round-robin, each prefixed by a header word
//   {2'b11, src_id[2:0], evt_cnt[10:0]}. A grant is only issued when the FIFO can
//   take a maximum-size frame plus overhead, and a source that stops writing for
//   TIMEOUT cycles has its frame aborted with a 16'hDEAD marker.
//   Optional feature macro: RDO_TRAILER_EN appends a trailer word
//   {2'b01, trunc, 1'b0, word_cnt[11:0]} after every frame (normal or aborted).
// Ports
//   clk_sys, rst            : clock, synchronous active-high reset
//   enable                  : 0 blocks new grants; a frame in flight completes
//   src_req/src_we/src_last : per-source request level, write pulse, last-word flag
//   src_data                : per-source 16-bit words, source i at [16*i+15:16*i]
//   src_gnt                 : one-hot grant (or zero)
//   fifo_free, fifo_full    : readout FIFO status
//   fifo_din, fifo_we       : readout FIFO write port
//   busy                    : arbiter not idle
//   err_overflow            : sticky, a word was dropped on fifo_full
//   err_timeout             : sticky, a frame was aborted by the stall timer
module rdo_fifo_arbiter #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned FRAME_MAX = 64,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N_SRC-1:0]      src_req,
    input  logic [N_SRC-1:0]      src_we,
    input  logic [N_SRC-1:0]      src_last,
    input  logic [16*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]      src_gnt,
    input  logic [11:0]           fifo_free,
    input  logic                  fifo_full,
    output logic [15:0]           fifo_din,
    output logic                  fifo_we,
    output logic                  busy,
    output logic                  err_overflow,
    output logic                  err_timeout
);
    localparam int unsigned ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned FREE_MIN = FRAME_MAX + 2;
    localparam logic [15:0] ABORT_WORD = 16'hDEAD;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_STREAM  = 3'd2,
        S_ABORT   = 3'd3
`ifdef RDO_TRAILER_EN
        , S_TRAILER = 3'd4
`endif
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [10:0]      evt_cnt;
    logic [11:0]      word_cnt;
    logic [TMR_W-1:0] idle_cnt;
    logic             trunc;

    logic [ID_W-1:0]  pick_c;
    logic             pick_vld_c;
    logic             free_ok_c;
    logic             win_we_c;
    logic             win_last_c;
    logic [15:0]      win_data_c;
    logic             drop_c;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        pick_c     = '0;
        pick_vld_c = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % N_SRC);
            if (!pick_vld_c && src_req[idx]) begin
                pick_c     = idx;
                pick_vld_c = 1'b1;
            end
        end
    end

    // Granted source's strobes/data; other sources never reach the FIFO.
    always_comb begin
        free_ok_c  = 32'(fifo_free) >= FREE_MIN;
        win_we_c   = src_we[win_id];
        win_last_c = src_last[win_id];
        win_data_c = src_data[32'(win_id)*16 +: 16];
        // Once truncation started the frame stays truncated until its last word.
        drop_c     = trunc || (32'(word_cnt) >= FRAME_MAX);
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state        <= S_IDLE;
            src_gnt      <= '0;
            fifo_din     <= '0;
            fifo_we      <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            win_id       <= '0;
            rr_ptr       <= '0;
            evt_cnt      <= '0;
            word_cnt     <= '0;
            idle_cnt     <= '0;
            trunc        <= 1'b0;
        end else begin
            fifo_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && pick_vld_c && free_ok_c) begin
                        win_id <= pick_c;
                        rr_ptr <= ID_W'((32'(pick_c) + 1) % N_SRC);
                        state  <= S_HEADER;
                        busy   <= 1'b1;
                    end
                end
                S_HEADER: begin
                    src_gnt  <= N_SRC'(1) << win_id;
                    fifo_din <= {2'b11, 3'(win_id), evt_cnt};
                    fifo_we  <= 1'b1;
                    evt_cnt  <= evt_cnt + 11'd1;
                    word_cnt <= '0;
                    idle_cnt <= '0;
                    trunc    <= 1'b0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (win_we_c) begin
                        idle_cnt <= '0;
                        if (drop_c) begin
                            trunc <= 1'b1;
                        end else if (fifo_full) begin
                            err_overflow <= 1'b1;
                        end else begin
                            fifo_din <= win_data_c;
                            fifo_we  <= 1'b1;
                            word_cnt <= word_cnt + 12'd1;
                        end
                        if (win_last_c) begin
                            src_gnt <= '0;
`ifdef RDO_TRAILER_EN
                            state   <= S_TRAILER;
`else
                            state   <= S_IDLE;
                            busy    <= 1'b0;
`endif
                        end
                    end else if (32'(idle_cnt) >= TIMEOUT - 1) begin
                        state <= S_ABORT;
                    end else begin
                        idle_cnt <= idle_cnt + TMR_W'(1);
                    end
                end
                S_ABORT: begin
                    src_gnt     <= '0;
                    fifo_din    <= ABORT_WORD;
                    fifo_we     <= 1'b1;
                    err_timeout <= 1'b1;
`ifdef RDO_TRAILER_EN
                    state       <= S_TRAILER;
`else
                    state       <= S_IDLE;
                    busy        <= 1'b0;
`endif
                end
`ifdef RDO_TRAILER_EN
                S_TRAILER: begin
                    fifo_din <= {2'b01, trunc, 1'b0, word_cnt};
                    fifo_we  <= 1'b1;
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdo_fifo_arbiter.sv
// tb_rdo_fifo_arbiter
//   Self-checking bench for rdo_fifo_arbiter (N_SRC=4, FRAME_MAX=64, TIMEOUT=4095).
//   Source agents emulate front-end controllers; a behavioural reference predicts
//   every output each cycle and literal word sequences pin the directed scenarios.
//   Honours RDO_TRAILER_EN when compiled with it.
module tb_rdo_fifo_arbiter;
    localparam int M_SRC     = 4;
    localparam int M_FRAME   = 64;
    localparam int M_TIMEOUT = 4095;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  src_req = '0;
    logic [3:0]  src_we = '0;
    logic [3:0]  src_last = '0;
    logic [63:0] src_data = '0;
    logic [3:0]  src_gnt;
    logic [11:0] fifo_free = 12'd100;
    logic        fifo_full = 1'b0;
    logic [15:0] fifo_din;
    logic        fifo_we;
    logic        busy;
    logic        err_overflow;
    logic        err_timeout;

    rdo_fifo_arbiter #(.N_SRC(4), .FRAME_MAX(64), .TIMEOUT(4095)) dut (
        .clk_sys(clk_sys), .rst(rst), .enable(enable),
        .src_req(src_req), .src_we(src_we), .src_last(src_last), .src_data(src_data),
        .src_gnt(src_gnt), .fifo_free(fifo_free), .fifo_full(fifo_full),
        .fifo_din(fifo_din), .fifo_we(fifo_we), .busy(busy),
        .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;
    logic [15:0] log_q[$];
    logic [3:0]  gnt_or = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: actual %h required %h", nm, $time, act, exp);
    endtask

    // ---------------- behavioural reference ----------------
    localparam int PH_IDLE = 0, PH_HDR = 1, PH_DATA = 2, PH_ABT = 3, PH_TRL = 4;
    int ph = PH_IDLE, m_win = 0, m_rr = 0, m_evt = 0, m_words = 0, m_quiet = 0;
    bit m_trunc = 1'b0;
    logic [3:0]  e_gnt = '0;
    logic [15:0] e_din = '0;
    logic e_we = 1'b0, e_busy = 1'b0, e_eovf = 1'b0, e_eto = 1'b0;

    always @(posedge clk_sys) begin
        if (rst) begin
            ph = PH_IDLE; m_win = 0; m_rr = 0; m_evt = 0; m_words = 0; m_quiet = 0;
            m_trunc = 1'b0; e_gnt = '0; e_din = '0; e_we = 1'b0; e_eovf = 1'b0; e_eto = 1'b0;
        end else begin
            e_we = 1'b0;
            case (ph)
                PH_IDLE: if (enable && src_req != 4'b0 && int'(fifo_free) >= M_FRAME + 2) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 0; k < M_SRC; k++) begin
                        int c;
                        c = (m_rr + k) % M_SRC;
                        if (!found && src_req[c]) begin m_win = c; found = 1'b1; end
                    end
                    m_rr = (m_win + 1) % M_SRC;
                    ph = PH_HDR;
                end
                PH_HDR: begin
                    e_gnt = 4'(1 << m_win);
                    e_din = 16'(32'hC000 + m_win * 2048 + m_evt);
                    e_we = 1'b1;
                    m_evt = (m_evt + 1) % 2048;
                    m_words = 0; m_quiet = 0; m_trunc = 1'b0;
                    ph = PH_DATA;
                end
                PH_DATA: if (src_we[m_win]) begin
                    m_quiet = 0;
                    if (m_words >= M_FRAME) m_trunc = 1'b1;
                    else if (fifo_full) e_eovf = 1'b1;
                    else begin
                        e_din = src_data[16*m_win +: 16];
                        e_we = 1'b1;
                        m_words++;
                    end
                    if (src_last[m_win]) begin
                        e_gnt = '0;
`ifdef RDO_TRAILER_EN
                        ph = PH_TRL;
`else
                        ph = PH_IDLE;
`endif
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet >= M_TIMEOUT) ph = PH_ABT;
                end
                PH_ABT: begin
                    e_gnt = '0; e_din = 16'hDEAD; e_we = 1'b1; e_eto = 1'b1;
`ifdef RDO_TRAILER_EN
                    ph = PH_TRL;
`else
                    ph = PH_IDLE;
`endif
                end
                default: begin
                    e_din = {2'b01, m_trunc, 1'b0, 12'(m_words)};
                    e_we = 1'b1;
                    ph = PH_IDLE;
                end
            endcase
        end
        e_busy = (ph != PH_IDLE);
    end

    // Per-cycle comparison plus FIFO word log for the directed sequences.
    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("cycle_outputs", 64'({src_gnt, fifo_din, fifo_we, busy, err_overflow, err_timeout}),
                  64'({e_gnt, e_din, e_we, e_busy, e_eovf, e_eto}));
            if (fifo_we) log_q.push_back(fifo_din);
            gnt_or = gnt_or | src_gnt;
        end
    end

    // ---------------- source agents ----------------
    int  we_pct = 100, junk_pct = 10, full_pct = 0, gap_max = 6, len_fix = 0;
    int  full_on_word = -1;
    bit  auto_req = 1'b0, fixed_data = 1'b1, rand_env = 1'b0;
    bit  pend[4], fin[4], seen_gnt[4];
    int  rem[4], sent[4], gap[4], stall_after[4];

    task automatic clear_agents();
        for (int i = 0; i < M_SRC; i++) begin
            pend[i] = 1'b0; fin[i] = 1'b0; seen_gnt[i] = 1'b0;
            rem[i] = 0; sent[i] = 0; gap[i] = 0; stall_after[i] = -1;
        end
        src_req = '0; src_we = '0; src_last = '0;
    endtask

    task automatic start_frame(input int i, input int len);
        pend[i] = 1'b1; fin[i] = 1'b0; seen_gnt[i] = 1'b0;
        rem[i] = len; sent[i] = 0; stall_after[i] = -1;
        src_req[i] = 1'b1;
    endtask

    task automatic drive_cycle();
        src_we = '0;
        src_last = '0;
        fifo_full = ($urandom_range(99) < full_pct);
        if (rand_env) begin
            enable = ($urandom_range(99) < 90);
            fifo_free = ($urandom_range(99) < 10) ? 12'($urandom_range(65)) : 12'(66 + $urandom_range(4029));
        end
        for (int i = 0; i < M_SRC; i++) begin
            if (pend[i]) begin
                if (fin[i] || (seen_gnt[i] && !src_gnt[i])) begin
                    pend[i] = 1'b0; fin[i] = 1'b0; seen_gnt[i] = 1'b0;
                    src_req[i] = 1'b0;
                    gap[i] = (gap_max > 0) ? $urandom_range(gap_max) : 0;
                end else if (src_gnt[i]) begin
                    seen_gnt[i] = 1'b1;
                    if (!(stall_after[i] >= 0 && sent[i] >= stall_after[i]) && $urandom_range(99) < we_pct) begin
                        sent[i]++;
                        src_we[i] = 1'b1;
                        src_data[16*i +: 16] = fixed_data ? 16'(32'hA000 + sent[i]) : 16'($urandom);
                        if (sent[i] == full_on_word) fifo_full = 1'b1;
                        if (sent[i] == rem[i]) begin src_last[i] = 1'b1; fin[i] = 1'b1; end
                    end
                end
            end else if (auto_req && gap[i] == 0) begin
                start_frame(i, (len_fix > 0) ? len_fix :
                            (($urandom_range(19) == 0) ? 60 + $urandom_range(12) : 1 + $urandom_range(7)));
            end else begin
                if (gap[i] > 0) gap[i]--;
                if ($urandom_range(99) < junk_pct) begin
                    src_we[i] = 1'b1;
                    src_last[i] = 1'($urandom_range(1));
                    src_data[16*i +: 16] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_sys);
            #1;
            drive_cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_agents();
        repeat (2) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        log_q.delete();
        gnt_or = '0;
    endtask

    task automatic check_seq(input string nm, input logic [15:0] exp[$]);
        check({nm, "_len"}, 64'(log_q.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            check($sformatf("%s_w%0d", nm, k), (k < log_q.size()) ? 64'(log_q[k]) : 64'hFFFF_FFFF, 64'(exp[k]));
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [15:0] exp[$];
        int n_data;
        logic [15:0] hdrs[$];

        clear_agents();
        do_reset();
        check("reset_outputs", 64'({src_gnt, fifo_din, fifo_we, busy, err_overflow, err_timeout}), 64'd0);

        // 1: single source 2, three words
        start_frame(2, 3);
        run(20);
        exp = '{16'hD000, 16'hA001, 16'hA002, 16'hA003};
`ifdef RDO_TRAILER_EN
        exp.push_back(16'h4003);
`endif
        check_seq("t1_fifo", exp);
        check("t1_gnt_seen", 64'(gnt_or), 64'h4);

        // 2: all sources, 1-word frames, continuous requests
        do_reset();
        auto_req = 1'b1; gap_max = 0; len_fix = 1;
        run(40);
        auto_req = 1'b0; gap_max = 6; len_fix = 0;
        run(10);
        hdrs.delete();
        foreach (log_q[k]) if (log_q[k][15:14] == 2'b11) hdrs.push_back(log_q[k]);
        exp = '{16'hC000, 16'hC801, 16'hD002, 16'hD803, 16'hC004};
        for (int k = 0; k < 5; k++)
            check($sformatf("t2_hdr%0d", k), (k < hdrs.size()) ? 64'(hdrs[k]) : 64'hFFFF_FFFF, 64'(exp[k]));

        // 3: FIFO space threshold
        do_reset();
        fifo_free = 12'd65;
        start_frame(1, 2);
        run(10);
        check("t3_busy_low", 64'(busy), 64'd0);
        check("t3_gnt_low", 64'(src_gnt), 64'd0);
        fifo_free = 12'd66;
        run(1);
        check("t3_busy_high", 64'(busy), 64'd1);
        run(12);
        fifo_free = 12'd100;
        exp = '{16'hC800, 16'hA001, 16'hA002};
`ifdef RDO_TRAILER_EN
        exp.push_back(16'h4002);
`endif
        check_seq("t3_fifo", exp);

        // 4: oversize frame truncation
        do_reset();
        start_frame(0, 70);
        run(100);
        n_data = 0;
        foreach (log_q[k]) if (log_q[k][15:14] == 2'b10) n_data++;
        check("t4_words_written", 64'(n_data), 64'd64);
        check("t4_no_overflow", 64'(err_overflow), 64'd0);
`ifdef RDO_TRAILER_EN
        check("t4_trailer", 64'(log_q[log_q.size()-1]), 64'h6040);
`else
        check("t4_last_word", 64'(log_q[log_q.size()-1]), 64'hA040);
`endif

        // 5: stalled source times out, next requester served
        do_reset();
        start_frame(3, 5);
        stall_after[3] = 2;
        run(5);
        start_frame(1, 2);
        run(4200);
        exp = '{16'hD800, 16'hA001, 16'hA002, 16'hDEAD};
`ifdef RDO_TRAILER_EN
        exp.push_back(16'h4002);
`endif
        exp.push_back(16'hC801); exp.push_back(16'hA001); exp.push_back(16'hA002);
`ifdef RDO_TRAILER_EN
        exp.push_back(16'h4002);
`endif
        check_seq("t5_fifo", exp);
        check("t5_err_timeout", 64'(err_timeout), 64'd1);
        check("t5_gnt_idle", 64'(src_gnt), 64'd0);

        // 6: overflow on word 2, then reset mid-frame
        do_reset();
        full_on_word = 2;
        start_frame(0, 4);
        run(20);
        full_on_word = -1;
        exp = '{16'hC000, 16'hA001, 16'hA003, 16'hA004};
`ifdef RDO_TRAILER_EN
        exp.push_back(16'h4003);
`endif
        check_seq("t6_fifo", exp);
        check("t6_err_overflow", 64'(err_overflow), 64'd1);
        we_pct = 50;
        start_frame(1, 10);
        for (int c = 0; c < 30 && !src_gnt[1]; c++) run(1);
        check("t6_granted", 64'(src_gnt), 64'h2);
        run(2);
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        clear_agents();
        @(posedge clk_sys);
        #1;
        check("t6_rst_outputs", 64'({src_gnt, fifo_din, fifo_we, busy, err_overflow, err_timeout}), 64'd0);
        rst = 1'b0;

        // randomized traffic against the reference
        do_reset();
        rand_env = 1'b1; auto_req = 1'b1; fixed_data = 1'b0;
        we_pct = 70; full_pct = 5; gap_max = 6; len_fix = 0;
        run(20000);
        rand_env = 1'b0; auto_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
